// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard unit.
// State encodings are fixed because state_o exposes them for debug.
package hazard_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      FLUSH    = 2'b01,
      MEM_WAIT = 2'b10,
      ST_RSV   = 2'b11
   } state_t;

   localparam int FLUSH_CYCLES_DEF = 2;

   function automatic logic load_use(
      input logic       mem_read,
      input logic [3:0] wr_addr,
      input logic [3:0] rs1,
      input logic [3:0] rs2,
      input logic       use1,
      input logic       use2
   );
      return mem_read &&
             ((use1 && (wr_addr == rs1)) ||
              (use2 && (wr_addr == rs2)));
   endfunction

endpackage

// File: rtl/hazard_if.sv
// Hazard unit signal bundle: pipeline status in, register controls out.
// master drives the pipeline status, slave is the hazard unit.
interface hazard_if;

   logic       idex_mem_read;
   logic [3:0] idex_write_address;
   logic [3:0] ifid_read_address1;
   logic [3:0] ifid_read_address2;
   logic       ifid_uses_rs1;
   logic       ifid_uses_rs2;
   logic       branch_taken;
   logic       mem_busy;

   logic       pc_write_en;
   logic       ifid_write_en;
   logic       exmem_write_en;
   logic       ifid_flush;
   logic       idex_flush;
   logic [1:0] state_o;

   modport master (
      output idex_mem_read,
      output idex_write_address,
      output ifid_read_address1,
      output ifid_read_address2,
      output ifid_uses_rs1,
      output ifid_uses_rs2,
      output branch_taken,
      output mem_busy,
      input  pc_write_en,
      input  ifid_write_en,
      input  exmem_write_en,
      input  ifid_flush,
      input  idex_flush,
      input  state_o
   );

   modport slave (
      input  idex_mem_read,
      input  idex_write_address,
      input  ifid_read_address1,
      input  ifid_read_address2,
      input  ifid_uses_rs1,
      input  ifid_uses_rs2,
      input  branch_taken,
      input  mem_busy,
      output pc_write_en,
      output ifid_write_en,
      output exmem_write_en,
      output ifid_flush,
      output idex_flush,
      output state_o
   );

endinterface

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at 0xFFFF instead of wrapping.
module sat_counter16 (
   input  logic        clk,
   input  logic        reset,
   input  logic        inc,
   output logic [15:0] count
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (inc && (count != 16'hFFFF)) begin
         count <= count + 16'd1;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, branch flush, memory freeze.
// Define HAZARD_STATS_EN to add saturating stall/flush statistics.
module hazard_unit
   import hazard_pkg::*;
#(
   parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   hazard_if.slave     hz
`ifdef HAZARD_STATS_EN
   ,
   output logic [15:0] stall_count,
   output logic [15:0] flush_count
`endif
);

   localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);

   state_t     state, nxt;
   logic [1:0] cnt, cnt_n;
   logic       pend, pend_n;

   logic pc_c, ifid_c, exmem_c;
   logic iff_c, idf_c;
   logic lu;
   logic do_idle, do_branch;

   assign lu = load_use(hz.idex_mem_read,
                        hz.idex_write_address,
                        hz.ifid_read_address1,
                        hz.ifid_read_address2,
                        hz.ifid_uses_rs1,
                        hz.ifid_uses_rs2);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= '0;
         pend  <= 1'b0;
      end else begin
         state <= nxt;
         cnt   <= cnt_n;
         pend  <= pend_n;
      end
   end

   always_comb begin
      nxt       = state;
      cnt_n     = cnt;
      pend_n    = pend;
      pc_c      = 1'b1;
      ifid_c    = 1'b1;
      exmem_c   = 1'b1;
      iff_c     = 1'b0;
      idf_c     = 1'b0;
      do_idle   = 1'b0;
      do_branch = 1'b0;

      unique case (state)
         IDLE: do_idle = 1'b1;
         FLUSH: begin
            iff_c = 1'b1;
            idf_c = 1'b1;
            if (hz.mem_busy) begin
               pc_c    = 1'b0;
               ifid_c  = 1'b0;
               exmem_c = 1'b0;
            end else begin
               cnt_n = cnt - 2'd1;
               if (cnt <= 2'd1) nxt = IDLE;
            end
         end
         MEM_WAIT: begin
            if (hz.mem_busy) begin
               pc_c    = 1'b0;
               ifid_c  = 1'b0;
               exmem_c = 1'b0;
               pend_n  = pend | hz.branch_taken;
            end else begin
               pend_n = 1'b0;
               if (pend) do_branch = 1'b1;
               else      do_idle   = 1'b1;
            end
         end
         default: nxt = IDLE;
      endcase

      // memory freeze outranks redirect, which outranks load-use
      if (do_idle) begin
         nxt = IDLE;
         priority case (1'b1)
            hz.mem_busy: begin
               pc_c    = 1'b0;
               ifid_c  = 1'b0;
               exmem_c = 1'b0;
               pend_n  = hz.branch_taken;
               nxt     = MEM_WAIT;
            end
            hz.branch_taken: do_branch = 1'b1;
            lu: begin
               pc_c   = 1'b0;
               ifid_c = 1'b0;
               idf_c  = 1'b1;
            end
            default: ;
         endcase
      end

      if (do_branch) begin
         iff_c = 1'b1;
         idf_c = 1'b1;
         cnt_n = CNT_INIT;
         nxt   = (CNT_INIT != 2'd0) ? FLUSH : IDLE;
      end
   end

   // reset holds the pipeline frozen with bubbles in IF/ID and ID/EX
   assign hz.pc_write_en    = reset & pc_c;
   assign hz.ifid_write_en  = reset & ifid_c;
   assign hz.exmem_write_en = reset & exmem_c;
   assign hz.ifid_flush     = ~reset | iff_c;
   assign hz.idex_flush     = ~reset | idf_c;
   assign hz.state_o        = state;

`ifdef HAZARD_STATS_EN
   logic stall_inc, flush_inc;

   assign stall_inc = reset & ~pc_c;
   // outside FLUSH, an IF/ID flush only happens on a branch start
   assign flush_inc = reset & iff_c & (state != FLUSH);

   sat_counter16 u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (stall_inc),
      .count (stall_count)
   );

   sat_counter16 u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (flush_inc),
      .count (flush_count)
   );
`endif

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles the IF/ID and ID/EX registers are flushed per taken branch; legal range 1..3.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port idex_mem_read  in  1  load instruction currently held in ID/EX.
REQ-005 SHALL have port idex_write_address  in  4  destination register held in ID/EX.
REQ-006 SHALL have ports ifid_read_address1 and ifid_read_address2  in  4 each  source registers of the instruction in decode.
REQ-007 SHALL have ports ifid_uses_rs1 and ifid_uses_rs2  in  1 each  the matching source register is actually read.
REQ-008 SHALL have port branch_taken  in  1  single-cycle redirect from branch resolution.
REQ-009 SHALL have port mem_busy  in  1  data memory not ready; the pipeline must freeze.
REQ-010 SHALL have ports pc_write_en, ifid_write_en and exmem_write_en  out  1 each  register update enables.
REQ-011 SHALL have ports ifid_flush and idex_flush  out  1 each  load a bubble (all zeros) into the register.
REQ-012 SHALL have port state_o  out  2  current FSM state, for debug.

Function
REQ-013 SHALL implement FSM states IDLE (00), FLUSH (01) and MEM_WAIT (10); state 11 SHALL return to IDLE.
REQ-014 Outputs SHALL be combinational from state and inputs (Mealy), with zero-cycle latency.
REQ-015 IDLE default SHALL be: all write enables 1, both flushes 0.
REQ-016 IDLE priority SHALL be: mem_busy > branch_taken > load-use.
REQ-017 IDLE with mem_busy SHALL drive all write enables 0 and flushes 0, and go to MEM_WAIT; a coincident branch_taken SHALL set pending_branch.
REQ-018 IDLE with branch_taken SHALL drive ifid_flush, idex_flush, pc_write_en and exmem_write_en to 1; it SHALL load cnt = FLUSH_CYCLES-1 and go to FLUSH if cnt>0, else stay in IDLE.
REQ-019 Load-use SHALL be detected when idex_mem_read=1 and idex_write_address equals an enabled ifid source address; all 16 addresses, including 0, are compared.
REQ-020 On load-use, pc_write_en and ifid_write_en SHALL be 0, idex_flush 1 and exmem_write_en 1, for exactly one cycle; the inserted bubble clears the condition.
REQ-021 FLUSH SHALL drive both flushes 1 and all write enables 1, and decrement cnt each cycle; at cnt=1 it SHALL go to IDLE.
REQ-022 FLUSH SHALL ignore branch_taken and load-use.
REQ-023 FLUSH with mem_busy SHALL freeze cnt, drive write enables 0 and keep flushes 1.
REQ-024 MEM_WAIT SHALL drive write enables 0 and flushes 0 while mem_busy=1, and SHALL capture any branch_taken into pending_branch.
REQ-025 On exit from MEM_WAIT (mem_busy=0) with pending_branch set, the exit cycle SHALL behave as the IDLE branch cycle of REQ-018 and clear pending_branch; otherwise it SHALL behave as an IDLE cycle.

Reset
REQ-026 reset low SHALL immediately force state IDLE, cnt 0 and pending_branch 0, even mid-FLUSH or mid-MEM_WAIT.
REQ-027 While reset is low, outputs SHALL be: write enables 0, ifid_flush 1, idex_flush 1, state_o 00.
REQ-028 After reset is deasserted, the first edge SHALL see IDLE default outputs.

Configuration
REQ-029 With HAZARD_STATS_EN defined, the module SHALL add outputs stall_count[15:0] (cycles with pc_write_en=0 outside reset) and flush_count[15:0] (branch flush starts); both SHALL saturate at 0xFFFF and reset to 0.
REQ-030 Without HAZARD_STATS_EN, those ports and their logic SHALL be absent, with no other behavioural change.

Structure
REQ-031 Package hazard_pkg SHALL hold the state encodings and the FLUSH_CYCLES default.
REQ-032 Sub-module sat_counter16 (16-bit saturating increment) SHALL be instantiated twice, only under HAZARD_STATS_EN.

Verification
REQ-033 Load-use: idex_mem_read=1, idex_write_address=5, ifid_read_address1=5, ifid_uses_rs1=1 -> one cycle of pc_write_en=0, ifid_write_en=0, idex_flush=1; the next cycle returns to IDLE defaults.
REQ-034 Masked source: same as REQ-033 but ifid_uses_rs1=0 -> no stall.
REQ-035 Branch: FLUSH_CYCLES=2, branch_taken pulse -> flushes high for exactly 2 cycles, state_o 00->01->00; with FLUSH_CYCLES=1, 1 cycle and no FLUSH state.
REQ-036 Memory stall: mem_busy high 3 cycles, with branch_taken in the 2nd -> enables 0 for 3 cycles, then a flush on the exit cycle; flush_count=1.
REQ-037 Reset mid-FLUSH: reset low during the first FLUSH cycle -> state_o 00 immediately, flushes 1, enables 0; after release, IDLE defaults and no residual flush.
REQ-038 Saturation (HAZARD_STATS_EN): hold a load-use stall for 70000 cycles -> stall_count stays at 0xFFFF.
